// File: rtl/fft_rom_streamer.sv
// fft_rom_streamer: reads the whole sample ROM in address order and emits it as one framed valid/ready stream.
module fft_rom_streamer #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_en,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_sof,
  output logic                  m_eof,
  output logic                  busy,
  output logic                  done
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_n;
  logic [ADDR_WIDTH:0] issue_cnt;
  logic [ADDR_WIDTH-1:0] issue_addr, last_addr;
  logic inflight, in_sof, in_eof, pop, last_issue, s1, f1;
  logic [1:0] occ, pos;
  logic [DATA_WIDTH-1:0] d1;
  assign issue_addr = issue_cnt[ADDR_WIDTH-1:0];
  assign last_issue = &issue_addr;
  assign m_valid = |occ;
  assign pop = m_valid & m_ready;
  assign pos = occ - {1'b0, pop};
  assign busy = state != IDLE;
  assign rom_addr = rom_en ? issue_addr : last_addr;
  // A read is issued only if the sample it returns is guaranteed a free buffer slot.
  always_comb begin
    rom_en = state == RUN && ({1'b0, occ} + {2'b0, inflight} - {2'b0, pop}) <= 3'd1;
    state_n = state;
    case (state)
      IDLE:    state_n = start ? RUN : IDLE;
      RUN:     state_n = rom_en && last_issue ? DRAIN : RUN;
      DRAIN:   state_n = pop && m_eof ? IDLE : DRAIN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      issue_cnt <= '0;
      last_addr <= '0;
      inflight <= 1'b0;
      in_sof <= 1'b0;
      in_eof <= 1'b0;
      occ <= 2'd0;
      m_data <= '0;
      m_sof <= 1'b0;
      m_eof <= 1'b0;
      d1 <= '0;
      s1 <= 1'b0;
      f1 <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      done <= state == DRAIN && pop && m_eof;
      inflight <= rom_en;
      occ <= occ + {1'b0, inflight} - {1'b0, pop};
      if (state == IDLE && start) issue_cnt <= '0;
      if (rom_en) begin
        issue_cnt <= issue_cnt + 1'b1;
        last_addr <= issue_addr;
        in_sof <= issue_cnt == '0;
        in_eof <= last_issue;
      end
      // Second entry is zeroed when it shifts to the head so an empty slot never holds stale tags.
      if (pop) begin
        m_data <= d1;
        m_sof <= s1;
        m_eof <= f1;
        d1 <= '0;
        s1 <= 1'b0;
        f1 <= 1'b0;
      end
      if (inflight && pos == 2'd0) begin
        m_data <= rom_data;
        m_sof <= in_sof;
        m_eof <= in_eof;
      end
      if (inflight && pos == 2'd1) begin
        d1 <= rom_data;
        s1 <= in_sof;
        f1 <= in_eof;
      end
    end
  end
endmodule

// File: tb/tb_fft_rom_streamer.sv
// tb_fft_rom_streamer: directed frames against a behavioural ROM (mem[k] = 16'h1000 + k).
module tb_fft_rom_streamer;
  localparam int N = 1024;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, m_ready = 1'b0;
  logic [9:0] rom_addr;
  logic rom_en, m_valid, m_sof, m_eof, busy, done;
  logic [15:0] rom_data = 16'h0, m_data;
  int n_cmp = 0, n_bad = 0, dc;
  logic any_act;

  fft_rom_streamer dut (
    .clk(clk), .rst(rst), .start(start), .rom_addr(rom_addr), .rom_en(rom_en),
    .rom_data(rom_data), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_sof(m_sof), .m_eof(m_eof), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (rom_en) rom_data <= 16'h1000 + {6'd0, rom_addr};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_rom_addr"}, 32'(rom_addr), 0);
    chk({tag, "_rom_en"}, 32'(rom_en), 0);
    chk({tag, "_m_data"}, 32'(m_data), 0);
    chk({tag, "_m_valid"}, 32'(m_valid), 0);
    chk({tag, "_m_sof"}, 32'(m_sof), 0);
    chk({tag, "_m_eof"}, 32'(m_eof), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
  endtask

  task automatic kick();
    @(posedge clk); #1;
    start = 1'b1;
    m_ready = 1'b1;
  endtask

  // mode 0: ready high, 1: random ready, 2: 20-cycle stall at sample 500.
  // Cycle c counts from the first cycle after the start edge; done_c is the cycle done was seen.
  task automatic stream(input int mode, input bit inj, input int rst_at, input bit chain, output int done_c);
    int idx, issued, occ, infl, stall_left, c;
    logic [15:0] pd;
    logic pv, pr, eof_hs, stalled, hs, after_stall;
    idx = 0; issued = 0; occ = 0; infl = 0; stall_left = 0; pd = '0;
    pv = 0; pr = 1; eof_hs = 0; stalled = 0; after_stall = 0; done_c = -1;
    for (c = 1; c < 8000 && done_c == -1; c++) begin
      @(posedge clk); #1;
      start = inj && (c == 10 || c == 200);
      if (idx == rst_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_quiet("mid_rst");
        done_c = -2;
        break;
      end
      if (mode == 2 && idx == 500 && !stalled) begin
        stall_left = 20;
        stalled = 1;
      end
      m_ready = mode == 1 ? 1'($urandom_range(0, 1)) : stall_left == 0;
      #1;
      hs = m_valid & m_ready;
      if (c == 1) begin
        chk("first_busy", 32'(busy), 1);
        chk("first_rom_en", 32'(rom_en), 1);
        chk("first_rom_addr", 32'(rom_addr), 0);
      end
      if (c == 3) chk("first_valid", 32'(m_valid), 1);
      if (pv && !pr) chk("hold_data", 32'(m_data), 32'(pd));
      if (rom_en) begin
        chk("credit", 32'(occ + infl - 32'(hs) <= 1), 1);
        chk("rom_addr_order", 32'(rom_addr), 32'(issued));
        issued++;
      end
      if (stall_left > 0) begin
        chk("stall_rom_en", 32'(rom_en), 0);
        if (stall_left == 1) begin
          chk("stall_buffered", 32'(issued - idx), 2);
          after_stall = 1;
        end
        stall_left--;
      end
      chk("done_timing", 32'(done), 32'(eof_hs));
      if (done) begin
        done_c = c;
        chk("busy_at_done", 32'(busy), 0);
        chk("issued_total", 32'(issued), N);
        if (chain) start = 1'b1;
      end
      eof_hs = hs & m_eof;
      if (hs) begin
        if (after_stall && m_ready) begin
          chk("resume_sample", 32'(m_data), 32'h11F4);
          after_stall = 0;
        end
        chk("sample", 32'(m_data), 32'(16'h1000 + 16'(idx)));
        chk("sof", 32'(m_sof), 32'(idx == 0));
        chk("eof", 32'(m_eof), 32'(idx == N - 1));
        idx++;
      end
      occ = occ + infl - 32'(hs);
      infl = 32'(rom_en);
      pv = m_valid; pr = m_ready; pd = m_data;
    end
    if (done_c == -1) chk("frame_timeout", 0, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_quiet("reset");
    rst = 1'b0;
    any_act = 1'b0;
    repeat (50) begin
      @(posedge clk); #1;
      any_act = any_act | rom_en | busy | m_valid;
    end
    chk("idle_quiet", 32'(any_act), 0);

    kick();
    stream(0, 0, -1, 0, dc);
    chk("full_rate_done_cycle", 32'(dc), 1027);
    @(posedge clk); #1;
    chk("after_done_busy", 32'(busy), 0);
    chk("after_done_pulse", 32'(done), 0);

    kick();
    stream(1, 0, -1, 0, dc);
    chk("random_done_seen", 32'(dc > 0), 1);

    kick();
    stream(2, 0, -1, 0, dc);
    chk("stall_done_cycle", 32'(dc), 1047);

    kick();
    stream(0, 1, -1, 1, dc);
    chk("inject_done_cycle", 32'(dc), 1027);
    stream(0, 0, -1, 0, dc);
    chk("b2b_done_cycle", 32'(dc), 1027);

    kick();
    stream(0, 0, 300, 0, dc);
    chk("mid_rst_abort", 32'(dc), 32'hFFFFFFFE);
    any_act = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      any_act = any_act | done | m_valid | rom_en;
    end
    chk("mid_rst_no_done", 32'(any_act), 0);
    kick();
    stream(0, 0, -1, 0, dc);
    chk("post_rst_done_cycle", 32'(dc), 1027);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
